// File: rtl/paddle_controller.sv
// Pong paddle front end. Debounces the player buttons, turns the screenEnd level into a
// one-cycle frame pulse, and moves each paddle once per frame within the playfield.

module paddle_debounce #(
    parameter int DB_CYCLES = 250000
) (
    input  logic clock,
    input  logic reset,
    input  logic raw,
    output logic level
);
    localparam int CW = $clog2(DB_CYCLES + 1);

    logic          s1, s2;
    logic [CW-1:0] cnt;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            level <= 1'b0;
            cnt   <= '0;
        end else begin
            s1 <= raw;
            s2 <= s1;
            if (s2 == level) begin
                cnt <= '0;
            end else if (cnt == CW'(DB_CYCLES - 1)) begin
                level <= s2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

module paddle_controller #(
    parameter int Y_LIM     = 480,
    parameter int PADDLE_H  = 64,
    parameter int PADDLE_W  = 10,
    parameter int P1_LEFT   = 20,
    parameter int P2_LEFT   = 610,
    parameter int SPEED     = 4,
    parameter int DB_CYCLES = 250000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       screenEnd,
    input  logic       btn_p1_up,
    input  logic       btn_p1_down,
    input  logic       btn_p2_up,
    input  logic       btn_p2_down,
    input  logic       recenter,
    output logic       posEdgeScreenEnd,
    output logic [9:0] p1_leftBound,
    output logic [9:0] p1_rightBound,
    output logic [9:0] p2_leftBound,
    output logic [9:0] p2_rightBound,
    output logic [8:0] p1_topBound,
    output logic [8:0] p1_bottomBound,
    output logic [8:0] p2_topBound,
    output logic [8:0] p2_bottomBound
);
    localparam int Y_INIT = (Y_LIM - PADDLE_H) / 2;
    localparam int Y_MAX  = Y_LIM - PADDLE_H;

    // db bit order: {p2_down, p2_up, p1_down, p1_up}
    logic [3:0] raw, db;
    logic       screen_end_d, tick;
    logic [8:0] ny1, ny2;

    assign raw = {btn_p2_down, btn_p2_up, btn_p1_down, btn_p1_up};

    for (genvar g = 0; g < 4; g++) begin : g_db
        paddle_debounce #(.DB_CYCLES(DB_CYCLES)) u_db (
            .clock (clock),
            .reset (reset),
            .raw   (raw[g]),
            .level (db[g])
        );
    end

    // 10-bit intermediate keeps y-SPEED and y+SPEED from wrapping
    function automatic logic [8:0] next_y(input logic [8:0] y, input logic up, input logic dn);
        logic [9:0] w;
        w = {1'b0, y};
        if (up && !dn)
            w = (w < 10'(SPEED)) ? 10'd0 : w - 10'(SPEED);
        else if (dn && !up)
            w = (w + 10'(SPEED) > 10'(Y_MAX)) ? 10'(Y_MAX) : w + 10'(SPEED);
        return w[8:0];
    endfunction

    assign tick = screenEnd & ~screen_end_d;
    assign ny1  = next_y(p1_topBound, db[0], db[1]);
    assign ny2  = next_y(p2_topBound, db[2], db[3]);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            screen_end_d     <= 1'b0;
            posEdgeScreenEnd <= 1'b0;
            p1_topBound      <= 9'(Y_INIT);
            p1_bottomBound   <= 9'(Y_INIT + PADDLE_H - 1);
            p2_topBound      <= 9'(Y_INIT);
            p2_bottomBound   <= 9'(Y_INIT + PADDLE_H - 1);
        end else begin
            screen_end_d     <= screenEnd;
            posEdgeScreenEnd <= tick;
            if (recenter) begin
                p1_topBound    <= 9'(Y_INIT);
                p1_bottomBound <= 9'(Y_INIT + PADDLE_H - 1);
                p2_topBound    <= 9'(Y_INIT);
                p2_bottomBound <= 9'(Y_INIT + PADDLE_H - 1);
            end else if (tick) begin
                p1_topBound    <= ny1;
                p1_bottomBound <= ny1 + 9'(PADDLE_H - 1);
                p2_topBound    <= ny2;
                p2_bottomBound <= ny2 + 9'(PADDLE_H - 1);
            end
        end
    end

    assign p1_leftBound  = 10'(P1_LEFT);
    assign p1_rightBound = 10'(P1_LEFT + PADDLE_W - 1);
    assign p2_leftBound  = 10'(P2_LEFT);
    assign p2_rightBound = 10'(P2_LEFT + PADDLE_W - 1);
endmodule
